// File: rtl/mac_sequencer.sv
// Command-side sequencer for the 32-bit MAC register. It buffers A/B operand pairs
// and on start issues clear + per-element accumulate commands, then captures the dot product.
module mac_sequencer #(
  parameter int MAX_LEN = 16,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [15:0]       wrA,
  input  logic [15:0]       wrB,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic [1:0]        macOpcode,
  output logic [15:0]       macA,
  output logic [15:0]       macB,
  input  logic [31:0]       macData,
  output logic [31:0]       result,
  output logic              resultValid,
  input  logic              resultReady
);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, HOLD} state_t;

  localparam logic [ADDR_W:0] MAX_LEN_C = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0] ONE_C     = (ADDR_W+1)'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   len_reg, len_next;
  logic [ADDR_W:0]   index_reg, index_next;
  logic [31:0]       result_reg, result_next;
  logic              valid_reg, valid_next;

  // Operand pairs stored packed as {A,B}; rd_reg is the registered read port.
  logic [31:0]       buf_mem [MAX_LEN];
  logic [31:0]       rd_reg;

  // The read address is index_next, so rd_reg already holds the element for the
  // index the ACCUM cycle is about to use. CLEAR re-reads entry 0 so a write landing
  // on the start edge is still seen.
  always_ff @(posedge clk) begin
    if (wrEn && (state_reg == IDLE)) begin
      buf_mem[wrAddr] <= {wrA, wrB};
    end
    rd_reg <= buf_mem[index_next[ADDR_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      len_reg    <= '0;
      index_reg  <= '0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      len_reg    <= len_next;
      index_reg  <= index_next;
      result_reg <= result_next;
      valid_reg  <= valid_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    len_next    = len_reg;
    index_next  = index_reg;
    result_next = result_reg;
    valid_next  = valid_reg;
    macOpcode   = 2'd0;
    macA        = 16'd0;
    macB        = 16'd0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          len_next   = (length > MAX_LEN_C) ? MAX_LEN_C : length;
          index_next = '0;
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        macOpcode  = 2'd1;
        index_next = '0;
        state_next = (len_reg == '0) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        macOpcode  = 2'd2;
        macA       = rd_reg[31:16];
        macB       = rd_reg[15:0];
        index_next = index_reg + ONE_C;
        if (index_reg == (len_reg - ONE_C)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        // The last accumulate has landed in the MAC register by now.
        result_next = macData;
        valid_next  = 1'b1;
        state_next  = HOLD;
      end
      HOLD: begin
        if (valid_reg && resultReady) begin
          valid_next = 1'b0;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy        = (state_reg != IDLE);
  assign result      = result_reg;
  assign resultValid = valid_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer with a behavioural MAC register model.
// Expected results go into a scoreboard queue; a monitor pops on each new result.
module tb_mac_sequencer;

  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [15:0]       wrA, wrB;
  logic              start;
  logic [ADDR_W:0]   length;
  logic              busy;
  logic [1:0]        macOpcode;
  logic [15:0]       macA, macB;
  logic [31:0]       macData;
  logic [31:0]       result;
  logic              resultValid;
  logic              resultReady;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  logic [1:0]  op_log[$];
  logic [15:0] a_log[$];
  logic [15:0] b_log[$];
  int          lat;
  logic        valid_seen = 1'b0;
  logic [31:0] mac_acc = 32'd0;

  always #5 clk = ~clk;

  mac_sequencer #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrA(wrA), .wrB(wrB),
    .start(start), .length(length), .busy(busy), .macOpcode(macOpcode),
    .macA(macA), .macB(macB), .macData(macData), .result(result),
    .resultValid(resultValid), .resultReady(resultReady)
  );

  // MAC register: hold / parallel load {a,b} / accumulate a*b modulo 2^32
  always @(posedge clk) begin
    case (macOpcode)
      2'd1: mac_acc <= {macA, macB};
      2'd2: mac_acc <= mac_acc + (32'(macA) * 32'(macB));
      default: ;
    endcase
  end
  assign macData = mac_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, req);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard head.
  always @(negedge clk) begin
    if (resultValid && !valid_seen) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL result: unexpected result 0x%08h with empty scoreboard", result);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL result: got=0x%08h want=0x%08h", result, e);
        end else begin
          $display("ok   result: 0x%08h", result);
        end
      end
    end
    valid_seen <= resultValid;
  end

  task automatic wr(input int addr, input logic [15:0] a, input logic [15:0] b);
    wrEn = 1'b1; wrAddr = ADDR_W'(addr); wrA = a; wrB = b;
    @(posedge clk); #1;
    wrEn = 1'b0;
  endtask

  // Start a run, log the command stream each cycle, wait (bounded) for resultValid.
  task automatic run(input int len, input logic [31:0] exp_res, input bit ack);
    op_log.delete(); a_log.delete(); b_log.delete();
    exp_q.push_back(exp_res);
    start = 1'b1; length = (ADDR_W+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!resultValid && lat < 40) begin
      op_log.push_back(macOpcode); a_log.push_back(macA); b_log.push_back(macB);
      @(posedge clk); #1;
      lat++;
    end
    if (!resultValid) begin
      total++; bad++;
      $display("FAIL timeout: resultValid not seen within 40 cycles (len=%0d)", len);
    end
    if (ack) begin
      resultReady = 1'b1;
      @(posedge clk); #1;
      resultReady = 1'b0;
      check("busy_after_ack", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; wrEn = 1'b0; wrAddr = '0; wrA = '0; wrB = '0;
    start = 1'b0; length = '0; resultReady = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(resultValid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_opcode", 32'(macOpcode), 32'd0);
    check("reset_macAB", {macA, macB}, 32'd0);
    reset = 1'b0;

    // Basic dot product {1,2,3}.{4,5,6} = 32
    wr(0, 16'd1, 16'd4); wr(1, 16'd2, 16'd5); wr(2, 16'd3, 16'd6);
    run(3, 32'd32, 1'b0);
    check("latency_len3", 32'(lat), 32'd5);
    for (int i = 0; i < 5 && i < op_log.size(); i++) begin
      logic [1:0] eop;
      eop = (i == 0) ? 2'd1 : ((i <= 3) ? 2'd2 : 2'd0);
      check($sformatf("opcode_seq[%0d]", i), 32'(op_log[i]), 32'(eop));
    end
    if (op_log.size() >= 4) begin
      check("macA_seq", {8'd0, a_log[1][7:0], a_log[2][7:0], a_log[3][7:0]}, 32'h00010203);
      check("macB_seq", {8'd0, b_log[1][7:0], b_log[2][7:0], b_log[3][7:0]}, 32'h00040506);
    end

    // Hold result with resultReady low; start and write must be ignored
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin start = 1'b1; length = 5'd1; end
      if (c == 2) begin wrEn = 1'b1; wrAddr = '0; wrA = 16'd9; wrB = 16'd9; end
      @(posedge clk); #1;
      start = 1'b0; wrEn = 1'b0;
      check($sformatf("hold_result[%0d]", c), result, 32'd32);
      check($sformatf("hold_busy[%0d]", c), 32'(busy), 32'd1);
    end
    resultReady = 1'b1;
    @(posedge clk); #1;
    resultReady = 1'b0;
    check("idle_after_hold", 32'(busy), 32'd0);
    check("valid_after_hold", 32'(resultValid), 32'd0);
    run(3, 32'd32, 1'b1);

    // Reset during the 2nd ACCUM cycle aborts without a result
    start = 1'b1; length = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_accum", 32'(macOpcode), 32'd2);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_valid", 32'(resultValid), 32'd0);
    check("abort_opcode", 32'(macOpcode), 32'd0);
    run(3, 32'd32, 1'b1);

    // Back-to-back: new start on the edge right after the handshake
    run(3, 32'd32, 1'b1);
    run(1, 32'd4, 1'b1);
    check("latency_len1", 32'(lat), 32'd3);

    // Modulo 2^32 wrap
    wr(0, 16'hFFFF, 16'hFFFF); wr(1, 16'hFFFF, 16'hFFFF);
    run(2, 32'hFFFC0002, 1'b1);

    // length = 0: clear only
    run(0, 32'd0, 1'b0);
    check("latency_len0", 32'(lat), 32'd2);
    check("len0_ops", {op_log.size() > 0 ? 16'(op_log[0]) : 16'hFFFF,
                       op_log.size() > 1 ? 16'(op_log[1]) : 16'hFFFF}, 32'h00010000);
    resultReady = 1'b1;
    @(posedge clk); #1;
    resultReady = 1'b0;

    // length > MAX_LEN clamps to 16
    for (int i = 0; i < MAX_LEN; i++) wr(i, 16'd1, 16'd1);
    run(20, 32'd16, 1'b1);
    check("latency_clamp", 32'(lat), 32'd18);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
Command-side driver for the 32-bit multiply-accumulate register. It holds two operand vectors in an internal buffer. On start it issues the register's opcode/a/b command stream: one clear, then one MAC per element. It then captures the accumulated dot product from the register's output and presents it on a valid/ready result port. It sits between the APU control logic and the MAC register and is the only block that drives that register's command inputs.

Parameters:
MAX_LEN, 16, operand buffer depth (entries of A/B pairs)
ADDR_W, 4, buffer address width, equal to log2(MAX_LEN)

Ports:
clk  input  1  system clock, all state changes on posedge
reset  input  1  synchronous, active-high reset
wrEn  input  1  operand buffer write strobe
wrAddr  input  ADDR_W  operand buffer write address
wrA  input  16  operand A written at wrAddr
wrB  input  16  operand B written at wrAddr
start  input  1  begin dot product over entries 0..length-1
length  input  ADDR_W+1  element count, sampled with start
busy  output  1  high whenever state is not IDLE
macOpcode  output  2  to MAC register: 0 = hold, 1 = parallel load {a,b}, 2 = accumulate a*b
macA  output  16  to MAC register operand a
macB  output  16  to MAC register operand b
macData  input  32  MAC register contents
result  output  32  captured dot product
resultValid  output  1  result available
resultReady  input  1  consumer accepts result

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE. busy=0, resultValid=0, result=0, macOpcode=0, macA=0, macB=0, index=0. Reset does not clear the buffer contents.
- Buffer writes: a write happens on a posedge when wrEn=1 and busy=0. While busy=1, writes are ignored.
- macOpcode, macA and macB are combinational decodes of state and index. They are 0/0/0 in every state other than CLEAR and ACCUM.
- IDLE:
  - start=1 latches len = min(length, MAX_LEN) and sets index=0, then goes to CLEAR.
  - start=0 stays in IDLE.
- CLEAR (one cycle): macOpcode=1, macA=0, macB=0. This zeroes the MAC register at the next edge.
  - len=0 goes to DRAIN.
  - Otherwise goes to ACCUM.
- ACCUM (len cycles): macOpcode=2, macA=bufA[index], macB=bufB[index]. index increments each cycle. After the cycle with index=len-1, go to DRAIN.
- DRAIN (one cycle): macOpcode=0. macData now reflects the final accumulation and is captured into result. resultValid is set. Go to HOLD.
- HOLD: result and resultValid are held stable. When resultValid=1 and resultReady=1 on an edge, clear resultValid and go to IDLE.
- Latency: with start sampled at edge E0, resultValid is high after edge E(len+2). A new start is accepted at the earliest on the edge after the handshake edge.
- start while busy=1 is ignored, including start asserted on the handshake edge.
- Arithmetic is done entirely in the MAC register: unsigned 16x16 product, 32-bit sum, modulo 2^32, no overflow flag. The sequencer never modifies the data.
- length > MAX_LEN is clamped to MAX_LEN. length=0 yields result=0.
- Reset asserted mid-operation (any state) returns to IDLE on that edge: macOpcode=0 and no partial result is presented. The MAC register contents are then stale but are never read before the next CLEAR.
- resultReady is ignored outside HOLD.

Test Plan:
- Write A={1,2,3}, B={4,5,6} to addr 0..2, start with length=3 -> macOpcode sequence 1,2,2,2,0. resultValid rises after E5, result=32 (0x00000020).
- Write A=B=0xFFFF to addr 0..1, length=2 -> result=0xFFFC0002 (modulo 2^32 wrap).
- length=0 -> CLEAR only, no ACCUM cycles, result=0 after E2. length=20 with all 16 entries A=1, B=1 -> result=16 (clamped).
- Hold resultReady=0 for 5 cycles after resultValid -> result stable, busy=1. A start pulse and a wrEn to addr 0 during that window are both ignored. Raising resultReady gives IDLE next cycle, and a rerun returns the same result.
- Assert reset during the 2nd ACCUM cycle of a length=3 run -> next cycle IDLE, busy=0, resultValid=0, macOpcode=0. Rerun without rewriting the buffer -> 32.
- Back-to-back runs: first run result=32, handshake, new start on the following edge with length=1 -> result=4 (register cleared, no carry-over).
